// File: rtl/fetch_unit_pkg.sv
// Shared core definitions for the instruction fetch unit: NOP encoding, reset vector, FSM states.
package fetch_unit_pkg;

  localparam logic [31:0] Nop              = 32'h0000_0013;
  localparam logic [31:0] DefaultResetAddr = 32'h8000_0000;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StValid,
    StAbort,
    StErr
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Fetch program counter: holds the next fetch address, advances by 4 or loads a redirect target.
// Honours FETCH_MISALIGN_CHECK_EN: when undefined the low two target bits are cleared.
module fetch_pc
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DefaultResetAddr
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        advance_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] target;

  always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned targets never reach here; the top diverts them to the error path.
    target = load_pc_i;
`else
    target = load_pc_i & ~32'h0000_0003;
`endif
  end

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = target;
    end else if (advance_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q <= RESET_ADDR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding Wishbone instruction fetch unit with redirect/abort handling.
// Optional misaligned-redirect fault reporting is enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = DefaultResetAddr
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] iwbm_addr_o,
  output logic        iwbm_cyc_o,
  output logic        iwbm_stb_o,
  input  logic [31:0] iwbm_dat_i,
  input  logic        iwbm_ack_i,
  input  logic        iwbm_err_i,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  output logic        e_fetch_err_o,
  output logic        e_inst_misaligned_o
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q;
  logic [31:0] abort_adr_q, abort_adr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        pc_load, pc_advance;
  logic        bus_done;
  logic        misaligned;

  assign bus_done = iwbm_ack_i | iwbm_err_i;

  always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
    misaligned = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
  end

  fetch_pc #(
    .RESET_ADDR(RESET_ADDR)
  ) u_fetch_pc (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (pc_load),
    .load_pc_i(redirect_pc_i),
    .advance_i(pc_advance),
    .pc_o     (pc_q)
  );

  always_comb begin
    state_d     = state_q;
    abort_adr_d = abort_adr_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;
    ferr_d      = ferr_q;
    pc_load     = 1'b0;
    pc_advance  = 1'b0;

    if (redirect_i) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      if (misaligned) begin
        // Fault is reported as a held entry; no bus cycle is issued for the bad target.
        valid_d  = 1'b1;
        pc_out_d = redirect_pc_i;
        instr_d  = Nop;
        state_d  = StErr;
      end else begin
        pc_load = 1'b1;
        unique case (state_q)
          StReq: begin
            if (bus_done) begin
              state_d = StReq;
            end else begin
              state_d     = StAbort;
              abort_adr_d = pc_q;
            end
          end
          StAbort: state_d = bus_done ? StReq : StAbort;
          default: state_d = StReq;
        endcase
      end
    end else begin
      unique case (state_q)
        StIdle: state_d = StReq;
        StReq: begin
          if (iwbm_ack_i) begin
            instr_d    = iwbm_dat_i;
            pc_out_d   = pc_q;
            valid_d    = 1'b1;
            pc_advance = 1'b1;
            state_d    = StValid;
          end else if (iwbm_err_i) begin
            instr_d  = Nop;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            ferr_d   = 1'b1;
            state_d  = StErr;
          end
        end
        StValid: begin
          if (!stall_i) begin
            valid_d = 1'b0;
            state_d = StReq;
          end
        end
        StErr: begin
          // Parked until a redirect; consuming the entry only retires valid.
          if (!stall_i) begin
            valid_d = 1'b0;
          end
        end
        StAbort: begin
          if (bus_done) begin
            state_d = StReq;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      abort_adr_q <= RESET_ADDR;
      instr_q     <= Nop;
      pc_out_q    <= RESET_ADDR;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      abort_adr_q <= abort_adr_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q, mis_d;

  always_comb begin
    mis_d = mis_q;
    if (redirect_i) begin
      mis_d = misaligned;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end

  assign e_inst_misaligned_o = mis_q;
`else
  assign e_inst_misaligned_o = 1'b0;
`endif

  // The aborted cycle must keep its original address until the slave completes it.
  assign iwbm_cyc_o    = (state_q == StReq) || (state_q == StAbort);
  assign iwbm_stb_o    = iwbm_cyc_o;
  assign iwbm_addr_o   = (state_q == StAbort) ? abort_adr_q : pc_q;
  assign instruction_o = instr_q;
  assign pc_o          = pc_out_q;
  assign valid_o       = valid_q;
  assign e_fetch_err_o = ferr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: bus requests and delivered entries are checked in order.
module tb_fetch_unit;

  localparam logic [31:0] NopW = 32'h0000_0013;

  typedef struct {
    bit          is_bus;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        ferr;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] addr;
  logic        cyc, stb;
  logic [31:0] dat;
  logic        ack, err;
  logic [31:0] instr, pc_out;
  logic        valid, ferr, mis;

  logic        slave_en, slave_ack, slave_err, force_ack;
  int unsigned lat;
  int unsigned cnt;
  logic [31:0] err_addr;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign dat = addr ^ 32'h8010_0093;
  assign ack = slave_en ? slave_ack : force_ack;
  assign err = slave_en ? slave_err : 1'b0;

  fetch_unit dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .stall_i            (stall),
    .redirect_i         (redirect),
    .redirect_pc_i      (redirect_pc),
    .iwbm_addr_o        (addr),
    .iwbm_cyc_o         (cyc),
    .iwbm_stb_o         (stb),
    .iwbm_dat_i         (dat),
    .iwbm_ack_i         (ack),
    .iwbm_err_i         (err),
    .instruction_o      (instr),
    .pc_o               (pc_out),
    .valid_o            (valid),
    .e_fetch_err_o      (ferr),
    .e_inst_misaligned_o(mis)
  );

  // Bus slave: completes each cycle after lat wait states, err at err_addr.
  initial begin
    slave_ack = 1'b0;
    slave_err = 1'b0;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      slave_ack = 1'b0;
      slave_err = 1'b0;
      if (!slave_en || !cyc || rst) begin
        cnt = 0;
      end else if (cnt < lat) begin
        cnt++;
      end else begin
        cnt = 0;
        if (addr == err_addr) slave_err = 1'b1;
        else slave_ack = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic void push_bus(input logic [31:0] a);
    exp_t e;
    e.is_bus = 1'b1; e.addr = a; e.instr = '0; e.ferr = 1'b0; e.mis = 1'b0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_ent(input logic [31:0] a, input logic [31:0] i, input logic fe,
                                   input logic mi);
    exp_t e;
    e.is_bus = 1'b0; e.addr = a; e.instr = i; e.ferr = fe; e.mis = mi;
    exp_q.push_back(e);
  endfunction

  // Monitor: new bus cycles and newly presented entries are popped and compared.
  initial begin
    logic        cyc_prev, done_prev, valid_prev;
    logic [31:0] pc_prev;
    exp_t        e;
    cyc_prev = 1'b0; done_prev = 1'b0; valid_prev = 1'b0; pc_prev = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cyc && (!cyc_prev || done_prev)) begin
          checks++;
          if (exp_q.size() == 0 || !exp_q[0].is_bus) begin
            errors++;
            $display("FAIL bus_req: got unexpected request at %h", addr);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end else begin
            e = exp_q.pop_front();
            if (addr !== e.addr || stb !== 1'b1) begin
              errors++;
              $display("FAIL bus_req: got addr %h stb %b expected addr %h stb 1", addr, stb,
                       e.addr);
            end
          end
        end
        if (valid && (!valid_prev || pc_out != pc_prev)) begin
          checks++;
          if (exp_q.size() == 0 || exp_q[0].is_bus) begin
            errors++;
            $display("FAIL entry: got unexpected entry pc %h instr %h", pc_out, instr);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end else begin
            e = exp_q.pop_front();
            if (pc_out !== e.addr || instr !== e.instr || ferr !== e.ferr || mis !== e.mis) begin
              errors++;
              $display("FAIL entry: got pc %h instr %h ferr %b mis %b expected %h %h %b %b",
                       pc_out, instr, ferr, mis, e.addr, e.instr, e.ferr, e.mis);
            end
          end
        end
      end
      cyc_prev   = cyc;
      done_prev  = ack | err;
      valid_prev = valid;
      pc_prev    = pc_out;
    end
  end

  task automatic wait_valid(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 60);
    if (!valid) check({name, "_timeout"}, 32'(valid), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] a);
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_pc = a;
    @(posedge clk); #1;
    redirect = 1'b0;
  endtask

  initial begin
    bit ok;
    int n;
    rst = 1'b1; stall = 1'b1; redirect = 1'b0; redirect_pc = '0;
    slave_en = 1'b1; force_ack = 1'b0; lat = 0; err_addr = 32'h8000_0008;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_ferr", 32'(ferr), 32'd0);
    check("rst_mis", 32'(mis), 32'd0);
    check("rst_instr", instr, NopW);
    check("rst_pc", pc_out, 32'h8000_0000);

    // First fetch, then hold under stall.
    push_bus(32'h8000_0000);
    push_ent(32'h8000_0000, 32'h0010_0093, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_valid("first");
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!valid || pc_out != 32'h8000_0000 || instr != 32'h0010_0093 || cyc) ok = 1'b0;
    end
    check("stall_hold", 32'(ok), 32'd1);

    // Release: sequential fetch, then a bus error at 8000_0008.
    push_bus(32'h8000_0004);
    push_ent(32'h8000_0004, 32'h0010_0097, 1'b0, 1'b0);
    push_bus(32'h8000_0008);
    push_ent(32'h8000_0008, NopW, 1'b1, 1'b0);
    @(posedge clk); #1;
    stall = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(valid && ferr) && n < 60);
    check("err_seen", 32'(valid && ferr), 32'd1);
    ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (cyc) ok = 1'b0;
    end
    check("err_no_bus", 32'(ok), 32'd1);

    // Redirect out of the error state.
    stall = 1'b1;
    push_bus(32'h8000_0200);
    push_ent(32'h8000_0200, 32'h0010_0293, 1'b0, 1'b0);
    do_redirect(32'h8000_0200);
    wait_valid("redir_200");

    // Redirect while a slow request is pending: abort keeps the old address.
    lat = 3;
    push_bus(32'h8000_0204);
    push_bus(32'h8000_0100);
    push_ent(32'h8000_0100, 32'h0010_0193, 1'b0, 1'b0);
    @(posedge clk); #1;
    stall = 1'b0;
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_pc = 32'h8000_0100;
    stall = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
    check("abort_addr", addr, 32'h8000_0204);
    check("abort_cyc", 32'(cyc), 32'd1);
    wait_valid("abort_done");
    lat = 0;

    // Misaligned redirect target.
`ifdef FETCH_MISALIGN_CHECK_EN
    push_ent(32'h8000_0102, NopW, 1'b0, 1'b1);
    do_redirect(32'h8000_0102);
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (cyc) ok = 1'b0;
    end
    check("misalign_no_bus", 32'(ok), 32'd1);
`else
    push_bus(32'h8000_0100);
    push_ent(32'h8000_0100, 32'h0010_0193, 1'b0, 1'b0);
    do_redirect(32'h8000_0102);
    wait_valid("misalign_fetch");
`endif

    // Wrap past the top of the address space.
    push_bus(32'hFFFF_FFFC);
    push_ent(32'hFFFF_FFFC, 32'h7FEF_FF6F, 1'b0, 1'b0);
    do_redirect(32'hFFFF_FFFC);
    wait_valid("wrap_fetch");
    push_bus(32'h0000_0000);
    slave_en = 1'b0;
    @(posedge clk); #1;
    stall = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cyc && n < 20);
    check("wrap_addr", addr, 32'h0000_0000);
    stall = 1'b1;

    // Reset with the bus cycle open, then a late ack.
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_drop_cyc", 32'(cyc), 32'd0);
    push_bus(32'h8000_0000);
    push_ent(32'h8000_0000, 32'h0010_0093, 1'b0, 1'b0);
    rst = 1'b0;
    force_ack = 1'b1;
    @(posedge clk); #1;
    force_ack = 1'b0;
    check("late_ack_valid", 32'(valid), 32'd0);
    slave_en = 1'b1;
    wait_valid("post_rst");
    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
